// File: rtl/alu_issue.sv
// RV32I R/I-type ALU issue stage: decodes an instruction into ALU control and
// operands, buffered in an output register plus one skid register.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_ctl,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CTLW = 4;
    localparam int unsigned RDW  = 5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [CTLW-1:0] ctl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RDW-1:0]  rd;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    entry_t or_q, or_d, sk_q, sk_d, dec;
    logic   in_ready_q, out_valid_q;
    logic   accept;

    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt, zero;
    logic       unused_rs1_field;

    assign f3   = in_instr[14:12];
    assign f7   = in_instr[31:25];
    assign alt  = (f7 == F7_ALT);
    assign zero = (f7 == F7_ZERO);
    assign unused_rs1_field = ^in_instr[19:15];

    // Base funct3 -> ALU control; alt selects SUB / SRA.
    function automatic logic [CTLW-1:0] base_ctl(input logic [2:0] fn3, input logic use_alt);
        logic [CTLW-1:0] c;
        case (fn3)
            3'b000:  c = use_alt ? 4'b0110 : 4'b0010;
            3'b001:  c = 4'b0100;
            3'b010:  c = 4'b1000;
            3'b011:  c = 4'b1001;
            3'b100:  c = 4'b0011;
            3'b101:  c = use_alt ? 4'b0111 : 4'b0101;
            3'b110:  c = 4'b0001;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Instruction decode into a buffer entry.
    always_comb begin
        dec         = '0;
        dec.a       = in_rs1_data;
        dec.b       = in_rs2_data;
        dec.rd      = in_instr[11:7];
        dec.illegal = 1'b1;
        case (in_instr[6:0])
            OP_R: begin
                if (zero || (alt && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.illegal = 1'b0;
                    dec.ctl     = base_ctl(f3, alt);
                end
            end
            OP_I: begin
                dec.b = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                if (!((f3 == 3'b001 && !zero) || (f3 == 3'b101 && !(zero || alt)))) begin
                    dec.illegal = 1'b0;
                    dec.ctl     = base_ctl(f3, alt && (f3 == 3'b101));
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready_q;

    // Occupancy FSM and buffer steering; flush overrides accept and pop.
    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        or_d    = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        or_d = dec;
                    end else if (accept) begin
                        sk_d    = dec;
                        state_d = TWO;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        or_d    = sk_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            or_q        <= '0;
            sk_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            or_q        <= or_d;
            sk_q        <= sk_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_alu_ctl = or_q.ctl;
    assign out_a       = or_q.a;
    assign out_b       = or_q.b;
    assign out_rd      = or_q.rd;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors plus randomized traffic
// checked against an instruction-level reference decoder.
module tb_alu_issue;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_rs1_data, in_rs2_data, out_a, out_b;
    logic [3:0]  out_alu_ctl;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctl(out_alu_ctl),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder written from the ISA mnemonic table.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        logic [3:0]  tbl [8];
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        legal;
        tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        e.a  = rs1;
        e.rd = instr[11:7];
        e.b  = (opc == 7'b0010011) ? {{20{instr[31]}}, instr[31:20]} : rs2;
        e.ctl = tbl[f3];
        legal = 1'b0;
        if (opc == 7'b0110011) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20) e.ctl = (f3 == 3'd0) ? 4'b0110 : 4'b0111;
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
            if (f3 == 3'd5 && f7 == 7'h20) e.ctl = 4'b0111;
        end
        e.ill = !legal;
        if (!legal) e.ctl = 4'b0000;
        return e;
    endfunction

    // Record every accepted instruction; flush drops everything buffered.
    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
        end
    end

    // Monitor: compare the presented entry with the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_ctl_rd_ill", 32'({out_alu_ctl, out_rd, out_illegal}), 32'd0);
            check("rst_a", out_a, 32'd0);
            check("rst_b", out_b, 32'd0);
        end else begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (out_valid && q.size() != 0) begin
                e = q[0];
                check("ctl", 32'(out_alu_ctl), 32'(e.ctl));
                check("a", out_a, e.a);
                check("b", out_b, e.b);
                check("rd", 32'(out_rd), 32'(e.rd));
                check("illegal", 32'(out_illegal), 32'(e.ill));
                if (out_ready && !flush) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned s;
        w = $urandom;
        s = $urandom_range(0, 9);
        w[6:0] = (s < 4) ? 7'b0110011 : (s < 8) ? 7'b0010011 : 7'($urandom);
        s = $urandom_range(0, 5);
        w[31:25] = (s < 2) ? 7'h00 : (s < 4) ? 7'h20 : 7'($urandom);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_ctl", 32'(out_alu_ctl), 32'd0);

        // Single ADD, one-cycle latency.
        step(); out_ready = 1'b1; put(32'h002081B3, 32'd5, 32'd7);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_ctl", 32'(out_alu_ctl), 32'h2);
        check("add_a", out_a, 32'd5);
        check("add_b", out_b, 32'd7);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_ill", 32'(out_illegal), 32'd0);

        // SUB then SRAI back-to-back.
        step(); put(32'h402081B3, 32'd9, 32'd3);
        step(); put(32'h4030D313, 32'h80000000, 32'd1);
        @(negedge clk);
        check("sub_ctl", 32'(out_alu_ctl), 32'h6);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("srai_ctl", 32'(out_alu_ctl), 32'h7);
        check("srai_b", out_b, 32'h00000403);
        check("srai_rd", 32'(out_rd), 32'd6);
        check("srai_a", out_a, 32'h80000000);

        // ADDI -1 then an all-zero word.
        step(); put(32'hFFF00293, 32'd11, 32'd12);
        step(); put(32'h00000000, 32'd13, 32'd14);
        @(negedge clk);
        check("addi_ctl", 32'(out_alu_ctl), 32'h2);
        check("addi_b", out_b, 32'hFFFFFFFF);
        check("addi_rd", 32'(out_rd), 32'd5);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("zero_ill", 32'(out_illegal), 32'd1);
        check("zero_ctl", 32'(out_alu_ctl), 32'h0);

        // Backpressure: three offered, two taken, then drain.
        step(); out_ready = 1'b0; put(32'h00308133, 32'd1, 32'd2);
        step(); put(32'h00418233, 32'd3, 32'd4);
        step(); put(32'h00520333, 32'd5, 32'd6);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_rd", 32'(out_rd), 32'd2);
        step();
        @(negedge clk);
        check("bp_hold_rd2", 32'(out_rd), 32'd2);
        step(); in_valid = 1'b0; out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        check("bp_second_rd", 32'(out_rd), 32'd4);
        step();
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush at occupancy two with input present.
        step(); out_ready = 1'b0; put(32'h00308133, 32'd1, 32'd2);
        step(); put(32'h00418233, 32'd3, 32'd4);
        step(); flush = 1'b1; put(32'h006283B3, 32'd7, 32'd8);
        step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush2_valid", 32'(out_valid), 32'd0);
        check("flush2_ready", 32'(in_ready), 32'd1);
        step();
        @(negedge clk);
        check("flush2_stays_empty", 32'(out_valid), 32'd0);

        // Flush at occupancy one: same-cycle input must be dropped.
        step(); out_ready = 1'b0; put(32'h00308133, 32'd1, 32'd2);
        step(); flush = 1'b1; put(32'h006283B3, 32'd7, 32'd8);
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush1_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while full.
        step(); put(32'h00308133, 32'd1, 32'd2);
        step(); put(32'h00418233, 32'd3, 32'd4);
        step(); in_valid = 1'b0;
        #2 rst_n = 1'b0; q.delete();
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_a", out_a, 32'd0);
        check("arst_rd", 32'(out_rd), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1; out_ready = 1'b1; put(32'h007302B3, 32'd21, 32'd22);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("arst_resume_valid", 32'(out_valid), 32'd1);
        check("arst_resume_rd", 32'(out_rd), 32'd5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            in_valid    = ($urandom_range(0, 3) != 0);
            in_instr    = rand_instr();
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 31) == 0);
        end
        step(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("final_drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 No parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream presents an instruction.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-007 in_instr  input  32  RV32I instruction word.
REQ-008 in_rs1_data  input  32  rs1 register value.
REQ-009 in_rs2_data  input  32  rs2 register value.
REQ-010 out_valid  output  1  ALU operation available.
REQ-011 out_ready  input  1  ALU stage accepts; transfer when out_valid && out_ready.
REQ-012 out_alu_ctl  output  4  ALU control code.
REQ-013 out_a  output  32  ALU operand A.
REQ-014 out_b  output  32  ALU operand B.
REQ-015 out_rd  output  5  destination register, instr[11:7].
REQ-016 out_illegal  output  1  instruction not decodable to an ALU op.

Function
REQ-017 Decode only opcode 0110011 (R) and 0010011 (I); out_a SHALL be in_rs1_data; out_b SHALL be in_rs2_data (R) or sign-extended instr[31:20] (I).
REQ-018 funct3 map: 000 ADD 0010 (R with funct7=0100000: SUB 0110); 001 SLL 0100; 010 SLT 1000; 011 SLTU 1001; 100 XOR 0011; 101 SRL 0101 / SRA 0111 (funct7=0100000); 110 OR 0001; 111 AND 0000.
REQ-019 I-type funct3=000 SHALL always decode ADD regardless of instr[31:25].
REQ-020 Illegal: any other opcode; R-type funct7 not 0000000/0100000; funct7=0100000 with R funct3 other than 000/101; I-type shift (001/101) with instr[31:25] other than 0000000 (001, 101) or 0100000 (101 only).
REQ-021 Illegal entries SHALL still be buffered and emitted with out_illegal=1, out_alu_ctl=0000, out_a/out_b/out_rd as captured.
REQ-022 Storage: output register (OR) plus one skid register (SK); occupancy 0, 1, 2.
REQ-023 in_ready SHALL be registered and equal to (SK empty); it SHALL NOT depend combinationally on out_ready.
REQ-024 Latency: accepted instruction appears on outputs the next cycle; throughput one per cycle when out_ready held 1.
REQ-025 Transitions: EMPTY+accept->ONE; ONE+accept+no pop->TWO (new entry to SK); ONE+accept+pop->ONE (new entry to OR); ONE+pop->EMPTY; TWO+pop->ONE (SK moves to OR); TWO never accepts.
REQ-026 Order SHALL be preserved; no entry duplicated or dropped.
REQ-027 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 flush SHALL empty OR and SK next cycle, ignore same-cycle input, deassert out_valid, and assert in_ready; flush overrides accept and pop.
REQ-029 out_ready with out_valid=0 SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately clear occupancy; out_valid=0, in_ready=1 after deassertion, out_alu_ctl=0, out_a=0, out_b=0, out_rd=0, out_illegal=0.
REQ-031 Reset mid-transfer SHALL discard all buffered entries; first accept after release yields output the following cycle.

Verification
REQ-032 in 0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ctl=0010, A=5, B=7, rd=3, illegal=0.
REQ-033 in 0x402081B3 then 0x4030D313 (rs1=0x80000000) back-to-back -> ctl 0110 then 0111 with B=0x00000403, rd=6; order kept.
REQ-034 0xFFF00293 -> ctl=0010, B=0xFFFFFFFF, rd=5; instr 0x00000000 -> illegal=1, ctl=0000.
REQ-035 out_ready=0, three valid inputs -> two accepted, in_ready=0 after second, outputs hold first; out_ready=1 -> drains in order, in_ready=1 one cycle later.
REQ-036 Occupancy 2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input absent from output.
REQ-037 rst_n pulsed low while occupancy 2 -> out_valid=0 during reset, all outputs zero, clean resume after release.
